fifo_rd_arb: RTL and testbench

Round-robin read-port arbiter that shares the read side of one asynchronous FIFO among NREQ consumers in the rclk domain. It watches the FIFO empty flag and first-word-fall-through read data, and grants the port to one requester at a time for bursts of up to MAXBURST words. It drives the FIFO pop strobe and delivers each popped word through a single registered output stage with per-requester valid/ready handshakes.

---
 rtl/fifo_rd_arb.sv | 144 ++++++++++++++
 tb/tb_fifo_rd_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb: round-robin arbiter sharing the read port of one async FIFO
// among NREQ consumers in the rclk domain. The granted requester receives
// bursts of up to MAXBURST words through one registered output stage.
module fifo_rd_arb #(
  parameter int DSIZE    = 32,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             fifo_rempty,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             fifo_rinc,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  out_ready,
  output logic [NREQ-1:0]  out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic [NREQ-1:0]  grant,
  output logic             busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXBURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_reg;
  logic [NREQ-1:0]  grant_reg;
  logic [GW-1:0]    g_reg;
  logic [GW-1:0]    last_reg;
  logic [CW-1:0]    cnt_reg;
  logic             ov_reg;
  logic [DSIZE-1:0] out_data_reg;

  logic [NREQ-1:0]  g_hot;
  logic [NREQ-1:0]  pick_hot;
  logic             pick_valid;
  logic [GW-1:0]    pick_idx;
  logic [GW-1:0]    rr_cand;
  int               rr_idx;
  logic             req_g;
  logic             ready_g;
  logic             pop;
  logic [CW-1:0]    cnt_next;
  logic             burst_done;

  // Decode the owner index and the round-robin pick into one-hot vectors
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_decode
      assign g_hot[gi]    = (g_reg == GW'(gi));
      assign pick_hot[gi] = (pick_idx == GW'(gi));
    end
  endgenerate

  // Only the owner's request/ready matter; other ready bits are ignored
  assign req_g   = |(req & g_hot);
  assign ready_g = |(out_ready & g_hot);

  // Pop only from registered state, the empty flag and the owner's handshake
  // so there is never a path from fifo_rdata to fifo_rinc.
  assign pop       = (state_reg == BURST) & req_g & ~fifo_rempty & (~ov_reg | ready_g);
  assign fifo_rinc = pop;

  assign cnt_next   = cnt_reg + CW'(1);
  assign burst_done = (cnt_next == CW'(MAXBURST));

  assign out_valid = ov_reg ? g_hot : '0;
  assign out_data  = out_data_reg;
  assign grant     = grant_reg;
  assign busy      = (state_reg != IDLE);

  // Round-robin search: first set req bit from (last+1) upward with wrap
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    rr_idx     = 0;
    rr_cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = int'(last_reg) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      rr_cand = GW'(rr_idx);
      if (!pick_valid && req[rr_cand]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_cand;
      end
    end
  end

  // Arbitration FSM with the registered output stage
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      g_reg        <= '0;
      last_reg     <= GW'(NREQ - 1);
      cnt_reg      <= '0;
      ov_reg       <= 1'b0;
      out_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_reg <= pick_hot;
            g_reg     <= pick_idx;
            cnt_reg   <= '0;
            state_reg <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            out_data_reg <= fifo_rdata;
            ov_reg       <= 1'b1;
            cnt_reg      <= cnt_next;
            if (burst_done) state_reg <= DRAIN;
          end else begin
            if (ready_g) ov_reg <= 1'b0;
            // An empty FIFO with the request still up keeps the grant
            if (!req_g) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // Wait for the owner to take the last word before releasing
          if (!ov_reg || ready_g) begin
            ov_reg    <= 1'b0;
            last_reg  <= g_reg;
            grant_reg <= '0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          ov_reg    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_arb.sv
// tb_fifo_rd_arb: FIFO model plus scoreboard; popped words are queued with
// their owner and compared when the consumer accepts them.
module tb_fifo_rd_arb;

  logic        rclk;
  logic        rrst_n;
  logic        fifo_rempty;
  logic [31:0] fifo_rdata;
  logic        fifo_rinc;
  logic [3:0]  req;
  logic [3:0]  out_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [3:0]  grant;
  logic        busy;

  fifo_rd_arb #(.DSIZE(32), .NREQ(4), .MAXBURST(8)) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rinc   (fifo_rinc),
    .req         (req),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .grant       (grant),
    .busy        (busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {int owner; logic [31:0] data;} sb_t;
  typedef struct {int owner; int cyc;} pl_t;

  logic [31:0] fifo_q[$];
  sb_t         exp_q[$];
  pl_t         pop_log[$];

  logic [3:0]  req_r;
  logic [3:0]  rdy_r;
  logic        force_empty;
  int          cyc;
  int          rx_cnt[4];
  int          chk_cnt;
  int          err_cnt;

  logic        s_rinc;
  logic        s_busy;
  logic [3:0]  s_grant;
  logic [3:0]  s_valid;
  logic [31:0] s_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int gidx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  // One clock cycle: drive at negedge, sample 1 unit later, return at next negedge
  task automatic cycle();
    sb_t         e;
    pl_t         p;
    logic [3:0]  oh;
    fifo_rempty = force_empty | (fifo_q.size() == 0);
    fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hBAD0_BAD0;
    req         = req_r;
    out_ready   = rdy_r;
    #1;
    s_rinc  = fifo_rinc;
    s_busy  = busy;
    s_grant = grant;
    s_valid = out_valid;
    s_data  = out_data;
    if (fifo_rempty) check_eq("rinc_while_empty", 32'(fifo_rinc), 32'd0);
    if (|out_valid) check_eq("valid_onehot", 32'($countones(out_valid)), 32'd1);
    if (|(out_valid & out_ready)) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_word", 32'(out_valid & out_ready), 32'd0);
      end else begin
        e = exp_q.pop_front();
        oh = 4'b0001 << e.owner;
        check_eq("sb_data", out_data, e.data);
        check_eq("sb_owner", 32'(out_valid), 32'(oh));
        rx_cnt[e.owner]++;
        $display("rx t=%0d owner=%0d data=%h", cyc, e.owner, out_data);
      end
    end
    if (fifo_rinc && fifo_q.size() != 0) begin
      e.owner = gidx(grant);
      e.data  = fifo_q.pop_front();
      exp_q.push_back(e);
      p.owner = e.owner;
      p.cyc   = cyc;
      pop_log.push_back(p);
    end
    cyc++;
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    req_r = '0; rdy_r = '0; force_empty = 1'b0;
    fifo_q.delete(); exp_q.delete(); pop_log.delete();
    for (int i = 0; i < 4; i++) rx_cnt[i] = 0;
    cycle();
    rrst_n = 1'b1;
  endtask

  // Drop requests, accept everything, wait (bounded) for idle and empty scoreboard
  task automatic finish_drain(input string tag);
    req_r = '0; rdy_r = 4'b1111; force_empty = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (!s_busy && exp_q.size() == 0) break;
    end
    check_eq({tag, "_drain_idle"}, 32'(s_busy), 32'd0);
    check_eq({tag, "_drain_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[20];
    int ro[$], rl[$], rf[$], rla[$];
    int exp_own[3];
    int exp_len[3];
    int total;
    chk_cnt = 0; err_cnt = 0; cyc = 0;
    rrst_n = 1'b0; req = '0; out_ready = '0; fifo_rempty = 1'b1; fifo_rdata = '0;
    req_r = '0; rdy_r = '0; force_empty = 1'b0;
    @(negedge rclk);

    // Reset state with requests pending and FIFO non-empty
    fifo_q.push_back(32'h1234_5678);
    req_r = 4'b1111; rdy_r = 4'b1111;
    cycle();
    check_eq("rst_grant", 32'(s_grant), 32'd0);
    check_eq("rst_valid", 32'(s_valid), 32'd0);
    check_eq("rst_busy", 32'(s_busy), 32'd0);
    check_eq("rst_rinc", 32'(s_rinc), 32'd0);
    check_eq("rst_data", s_data, 32'd0);

    // Basic: three words to requester 0
    do_reset();
    w[0] = 32'hA000_000A; w[1] = 32'hB000_000B; w[2] = 32'hC000_000C;
    for (int i = 0; i < 3; i++) fifo_q.push_back(w[i]);
    req_r = 4'b0001; rdy_r = 4'b0001;
    cycle();
    check_eq("basic_pre_grant", 32'(s_grant), 32'd0);
    check_eq("basic_pre_rinc", 32'(s_rinc), 32'd0);
    cycle();
    check_eq("basic_grant", 32'(s_grant), 32'b0001);
    check_eq("basic_busy", 32'(s_busy), 32'd1);
    check_eq("basic_rinc0", 32'(s_rinc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("basic_rinc", 32'(s_rinc), (i < 2) ? 32'd1 : 32'd0);
      check_eq("basic_valid", 32'(s_valid), 32'b0001);
      check_eq("basic_data", s_data, w[i]);
    end
    cycle();
    check_eq("basic_wait_valid", 32'(s_valid), 32'd0);
    check_eq("basic_wait_busy", 32'(s_busy), 32'd1);
    check_eq("basic_wait_grant", 32'(s_grant), 32'b0001);
    finish_drain("basic");

    // Burst limit and round-robin: 20 words, all requesting
    do_reset();
    for (int i = 0; i < 20; i++) fifo_q.push_back(32'h2000_0000 + 32'(i));
    req_r = 4'b1111; rdy_r = 4'b1111;
    for (int i = 0; i < 40; i++) cycle();
    foreach (pop_log[i]) begin
      if (ro.size() == 0 || ro[ro.size()-1] != pop_log[i].owner) begin
        ro.push_back(pop_log[i].owner); rl.push_back(1);
        rf.push_back(pop_log[i].cyc); rla.push_back(pop_log[i].cyc);
      end else begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
        rla[rla.size()-1] = pop_log[i].cyc;
      end
    end
    exp_own = '{0, 1, 2};
    exp_len = '{8, 8, 4};
    check_eq("rr_num_bursts", 32'(ro.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < ro.size()) begin
        check_eq("rr_owner", 32'(ro[i]), 32'(exp_own[i]));
        check_eq("rr_len", 32'(rl[i]), 32'(exp_len[i]));
        check_eq("rr_back_to_back", 32'(rla[i] - rf[i]), 32'(rl[i] - 1));
        if (i > 0) check_eq("rr_handover_gap", 32'(rf[i] - rla[i-1]), 32'd3);
      end
    end
    finish_drain("rr");
    check_eq("rr_total", 32'(rx_cnt[0] + rx_cnt[1] + rx_cnt[2] + rx_cnt[3]), 32'd20);

    // Backpressure: ready low 5 cycles after first word
    do_reset();
    for (int i = 0; i < 10; i++) begin
      w[i] = 32'h3000_0000 + 32'(i);
      fifo_q.push_back(w[i]);
    end
    req_r = 4'b0001; rdy_r = 4'b0001;
    cycle();
    cycle();
    check_eq("bp_first_pop", 32'(s_rinc), 32'd1);
    rdy_r = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("bp_hold_rinc", 32'(s_rinc), 32'd0);
      check_eq("bp_hold_valid", 32'(s_valid), 32'b0001);
      check_eq("bp_hold_data", s_data, w[0]);
    end
    rdy_r = 4'b0001;
    cycle();
    check_eq("bp_resume_rinc", 32'(s_rinc), 32'd1);
    cycle();
    check_eq("bp_next_valid", 32'(s_valid), 32'b0001);
    check_eq("bp_next_data", s_data, w[1]);
    finish_drain("bp");

    // Early release: owner 0 drops req with a word pending and ready low
    do_reset();
    for (int i = 0; i < 6; i++) fifo_q.push_back(32'h4000_0000 + 32'(i));
    req_r = 4'b0011; rdy_r = 4'b0001;
    cycle();
    cycle();
    check_eq("er_grant0", 32'(s_grant), 32'b0001);
    cycle();
    req_r = 4'b0010; rdy_r = 4'b0000;
    cycle();
    check_eq("er_no_pop_after_drop", 32'(s_rinc), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("er_drain_rinc", 32'(s_rinc), 32'd0);
      check_eq("er_drain_busy", 32'(s_busy), 32'd1);
      check_eq("er_drain_valid", 32'(s_valid), 32'b0001);
      check_eq("er_drain_data", s_data, 32'h4000_0001);
    end
    rdy_r = 4'b0011;
    cycle();
    cycle();
    check_eq("er_idle_busy", 32'(s_busy), 32'd0);
    check_eq("er_idle_grant", 32'(s_grant), 32'd0);
    cycle();
    check_eq("er_next_grant", 32'(s_grant), 32'b0010);
    check_eq("er_next_rinc", 32'(s_rinc), 32'd1);
    finish_drain("er");

    // Empty guard: random empty flag and ready under full request
    do_reset();
    for (int i = 0; i < 40; i++) fifo_q.push_back($urandom);
    req_r = 4'b1111;
    for (int i = 0; i < 300; i++) begin
      force_empty = 1'($urandom_range(0, 1));
      rdy_r = 4'($urandom_range(0, 15));
      cycle();
    end
    force_empty = 1'b0; rdy_r = 4'b1111;
    for (int i = 0; i < 300; i++) begin
      if (fifo_q.size() == 0) break;
      cycle();
    end
    check_eq("guard_fifo_drained", 32'(fifo_q.size()), 32'd0);
    finish_drain("guard");
    total = rx_cnt[0] + rx_cnt[1] + rx_cnt[2] + rx_cnt[3];
    check_eq("guard_rx_total", 32'(total), 32'd40);

    // Reset mid-burst with a word held in the output register
    do_reset();
    for (int i = 0; i < 5; i++) fifo_q.push_back(32'h5000_0000 + 32'(i));
    req_r = 4'b0001; rdy_r = 4'b0000;
    cycle();
    cycle();
    cycle();
    check_eq("mr_valid_before", 32'(s_valid), 32'b0001);
    #2;
    rrst_n = 1'b0;
    #1;
    check_eq("mr_async_valid", 32'(out_valid), 32'd0);
    check_eq("mr_async_grant", 32'(grant), 32'd0);
    check_eq("mr_async_busy", 32'(busy), 32'd0);
    check_eq("mr_async_rinc", 32'(fifo_rinc), 32'd0);
    exp_q.delete();
    @(negedge rclk);
    rrst_n = 1'b1;
    req_r = 4'b1000; rdy_r = 4'b1000;
    cycle();
    cycle();
    check_eq("mr_grant3", 32'(s_grant), 32'b1000);
    cycle();
    check_eq("mr_data", s_data, 32'h5000_0001);
    finish_drain("mr");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
